// File: rtl/eth_spi_pkg.sv
// Shared constants and types for the Ethernet SPI responder.
//   SPI_BYTE_BITS     : bits per SPI byte
//   FILL_BYTE_DEFAULT : byte sent on MISO when the host has nothing queued
//   spi_state_t       : frame state (IDLE, ACTIVE)
package eth_spi_pkg;

    localparam int         SPI_BYTE_BITS     = 8;
    localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, followed by a
// single edge-detect register.
//   clk_in, rst_n : system clock, synchronous active-low reset
//   din           : asynchronous pin
//   level         : synchronised level
//   rise / fall   : single-cycle edge pulses, derived from the synchronised
//                   level and the edge-detect register
// Reset loads every flop with RESET_VAL, so an idle bus produces no edge
// when reset is released.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  =  level & ~prev_q;
    assign fall  = ~level &  prev_q;

endmodule

// File: rtl/eth_spi_responder.sv
// SPI mode-0 responder standing in for the Ethernet controller.
// Oversamples eth_sck/eth_cs/eth_mosi on clk_in, deserialises MOSI into
// bytes and serialises a host-supplied response stream onto MISO.
//   clk_in, rst_n      : system clock, synchronous active-low reset
//   eth_sck/cs/mosi    : asynchronous SPI inputs (cs active-low)
//   eth_miso           : serial response, idles high
//   rx_data, rx_valid  : last received byte, one-cycle update pulse
//   tx_data, tx_load   : host response byte, accepted when tx_ready=1
//   tx_ready           : one-byte response buffer is empty
//   frame_start/end    : one-cycle pulses on cs fall / rise
//   byte_count         : complete bytes in the current/last frame (saturates)
//   underrun           : sticky, FILL_BYTE was sent since frame_start
module eth_spi_responder
    import eth_spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = FILL_BYTE_DEFAULT,
    parameter int         CNT_W       = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             eth_sck,
    input  logic             eth_cs,
    input  logic             eth_mosi,
    output logic             eth_miso,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic [7:0]       tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic             frame_start,
    output logic             frame_end,
    output logic [CNT_W-1:0] byte_count,
    output logic             underrun
);

    localparam logic [2:0] LAST_BIT = 3'(SPI_BYTE_BITS - 1);

    // ---------------- input synchronisers ----------------
    logic sck_lvl_unused, sck_rise, sck_fall;
    logic cs_lvl_unused, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck (
        .clk_in(clk_in), .rst_n(rst_n), .din(eth_sck),
        .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
        .clk_in(clk_in), .rst_n(rst_n), .din(eth_cs),
        .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
    );

    // Same depth as the sck path, so mosi_s is aligned with sck_rise.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
        .clk_in(clk_in), .rst_n(rst_n), .din(eth_mosi),
        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    // ---------------- frame state machine ----------------
    spi_state_t state, state_d;
    logic       do_start, do_end, do_sample, do_shift;

    always_ff @(posedge clk_in) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // A cs edge wins over an sck edge in the same cycle; sck is ignored in IDLE.
    always_comb begin
        state_d   = state;
        do_start  = 1'b0;
        do_end    = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_d  = ACTIVE;
                    do_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    do_end  = 1'b1;
                end else if (sck_rise) begin
                    do_sample = 1'b1;
                end else if (sck_fall) begin
                    do_shift = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    logic [2:0] bit_cnt;
    logic [6:0] shift_in;     // first seven bits of the byte in flight
    logic [6:0] shift_out;    // bits still to go after the one on MISO
    logic       reload_pend;
    logic       buf_full;
    logic [7:0] buf_data;
    logic       do_load;
    logic [7:0] next_byte;

    assign do_load   = do_start | (do_shift & reload_pend);
    assign next_byte = buf_full ? buf_data : FILL_BYTE;
    assign tx_ready  = ~buf_full;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            eth_miso    <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            byte_count  <= '0;
            underrun    <= 1'b0;
            bit_cnt     <= '0;
            shift_in    <= '0;
            shift_out   <= '0;
            reload_pend <= 1'b0;
            buf_full    <= 1'b0;
            buf_data    <= '0;
        end else begin
            rx_valid    <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;

            if (do_load) begin
                shift_out <= next_byte[6:0];
                eth_miso  <= next_byte[7];
            end

            if (do_start) begin
                frame_start <= 1'b1;
                byte_count  <= '0;
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
                underrun    <= ~buf_full;
            end else if (do_load && !buf_full) begin
                underrun <= 1'b1;
            end

            if (do_shift) begin
                if (reload_pend) begin
                    reload_pend <= 1'b0;
                end else begin
                    shift_out <= {shift_out[5:0], 1'b0};
                    eth_miso  <= shift_out[6];
                end
            end

            if (do_sample) begin
                shift_in <= {shift_in[5:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == LAST_BIT) begin
                    rx_data     <= {shift_in, mosi_s};
                    rx_valid    <= 1'b1;
                    reload_pend <= 1'b1;
                    if (byte_count != {CNT_W{1'b1}})
                        byte_count <= byte_count + 1'b1;
                end
            end

            // Partial byte is simply dropped: bit_cnt is cleared at next start.
            if (do_end) begin
                frame_end <= 1'b1;
                eth_miso  <= 1'b1;
            end

            // The buffer drains only when full and accepts only when empty,
            // so a same-cycle load during a drain is refused.
            if (tx_load && !buf_full) begin
                buf_full <= 1'b1;
                buf_data <= tx_data;
            end else if (do_load && buf_full) begin
                buf_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_spi_responder.sv
module tb_eth_spi_responder;

    localparam int         CW   = 3;
    localparam logic [7:0] FILL = 8'hFF;

    logic          clk_in = 1'b0;
    logic          rst_n = 1'b0;
    logic          eth_sck = 1'b0, eth_cs = 1'b1, eth_mosi = 1'b0;
    logic          eth_miso;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_load = 1'b0;
    logic          tx_ready, frame_start, frame_end, underrun;
    logic [CW-1:0] byte_count;

    always #5 clk_in = ~clk_in;

    eth_spi_responder #(.SYNC_STAGES(2), .FILL_BYTE(FILL), .CNT_W(CW)) dut (
        .clk_in(clk_in), .rst_n(rst_n),
        .eth_sck(eth_sck), .eth_cs(eth_cs), .eth_mosi(eth_mosi), .eth_miso(eth_miso),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .frame_start(frame_start), .frame_end(frame_end),
        .byte_count(byte_count), .underrun(underrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Scoreboard queues (expected) and observed MISO bytes from the initiator.
    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];
    logic [7:0] obs_miso[$];
    int         exp_cnt[$];
    bit         exp_unr[$];
    bit         exp_start_unr[$];
    logic [7:0] mosi_q[$];

    // Reference model of the one-byte response buffer.
    bit         m_full = 1'b0;
    logic [7:0] m_buf = 8'h00;
    bit         refill_mode = 1'b0;

    task automatic model_load(output logic [7:0] b, inout bit unr);
        if (m_full) begin
            b = m_buf;
            m_full = 1'b0;
            if (refill_mode) begin
                m_buf  = 8'h01;
                m_full = 1'b1;
            end
        end else begin
            b   = FILL;
            unr = 1'b1;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic host_load(input logic [7:0] x);
        chk("tx_ready before load", tx_ready, !m_full);
        tx_data = x;
        tx_load = 1'b1;
        cyc(1);
        tx_load = 1'b0;
        if (!m_full) begin
            m_buf  = x;
            m_full = 1'b1;
        end
    endtask

    // One SPI mode-0 frame: nbytes full bytes, then partial extra sck pulses
    // with cs released while sck is still high after the last of them.
    task automatic frame(input int nbytes, input int partial, input int half);
        logic [7:0] mb[];
        logic [7:0] cur, got;
        bit         unr;
        unr = 1'b0;
        mb  = new[nbytes];
        model_load(cur, unr);
        exp_start_unr.push_back(unr);
        for (int i = 0; i < nbytes; i++) begin
            mb[i] = (mosi_q.size() > 0) ? mosi_q.pop_front() : 8'($urandom);
            exp_rx.push_back(mb[i]);
            exp_miso.push_back(cur);
            model_load(cur, unr);
        end
        exp_cnt.push_back(nbytes > 7 ? 7 : nbytes);
        exp_unr.push_back(unr);

        got = 8'h00;
        eth_cs = 1'b0;
        cyc(half);
        for (int i = 0; i < nbytes; i++) begin
            for (int b = 7; b >= 0; b--) begin
                eth_mosi = mb[i][b];
                cyc(half);
                got[b] = eth_miso;
                eth_sck = 1'b1;
                cyc(half);
                eth_sck = 1'b0;
            end
            obs_miso.push_back(got);
        end
        if (partial > 0) begin
            for (int b = 0; b < partial; b++) begin
                eth_mosi = 1'($urandom);
                cyc(half);
                eth_sck = 1'b1;
                cyc(half);
                if (b < partial - 1) eth_sck = 1'b0;
            end
            eth_cs = 1'b1;
            cyc(half);
            eth_sck = 1'b0;
            cyc(half);
        end else begin
            cyc(half);
            eth_cs = 1'b1;
            cyc(2 * half);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk_in) begin
        if (rst_n) begin
            if (rx_valid) begin
                if (exp_rx.size() == 0) chk("unexpected rx_valid", rx_valid, 1'b0);
                else                    chk("rx_data", rx_data, exp_rx.pop_front());
            end
            if (frame_start) begin
                if (exp_start_unr.size() == 0) chk("unexpected frame_start", frame_start, 1'b0);
                else begin
                    chk("underrun at start", underrun, exp_start_unr.pop_front());
                    chk("byte_count at start", byte_count, 0);
                end
            end
            if (frame_end) begin
                if (exp_cnt.size() == 0) chk("unexpected frame_end", frame_end, 1'b0);
                else begin
                    chk("byte_count at end", byte_count, exp_cnt.pop_front());
                    chk("underrun at end", underrun, exp_unr.pop_front());
                end
            end
            if (obs_miso.size() > 0) begin
                if (exp_miso.size() == 0) chk("unexpected miso byte", obs_miso.size(), 0);
                else                      chk("miso byte", obs_miso.pop_front(), exp_miso.pop_front());
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, " eth_miso"}, eth_miso, 1'b1);
        chk({tag, " rx_data"}, rx_data, 8'h00);
        chk({tag, " rx_valid"}, rx_valid, 1'b0);
        chk({tag, " tx_ready"}, tx_ready, 1'b1);
        chk({tag, " frame_start"}, frame_start, 1'b0);
        chk({tag, " frame_end"}, frame_end, 1'b0);
        chk({tag, " byte_count"}, byte_count, 0);
        chk({tag, " underrun"}, underrun, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cyc(4);

        // Loopback at sck period 16.
        host_load(8'hA5);
        mosi_q.push_back(8'h3C);
        frame(1, 0, 8);

        // Underrun: one preloaded byte then FILL.
        host_load(8'h12);
        frame(3, 0, 8);

        // Back-to-back reload of 8'h01 whenever the buffer empties.
        host_load(8'h01);
        refill_mode = 1'b1;
        fork
            begin
                while (refill_mode) begin
                    tx_data = 8'h01;
                    tx_load = tx_ready;
                    cyc(1);
                end
                tx_load = 1'b0;
            end
        join_none
        frame(4, 0, 8);
        refill_mode = 1'b0;
        cyc(3);

        // Partial byte: 3 rises / 2 falls, cs rises with sck high.
        frame(0, 3, 8);

        // Load while buffer full is dropped.
        host_load(8'h5A);
        host_load(8'hC3);
        frame(2, 0, 4);

        // cs toggle with no sck.
        frame(0, 0, 5);

        // Minimum sck phase.
        host_load(8'h96);
        frame(3, 0, 4);

        // Reset mid-frame during bit 3: no frame_end, outputs at reset values.
        begin
            logic [7:0] cur;
            bit         unr;
            unr = 1'b0;
            host_load(8'hE7);
            model_load(cur, unr);
            exp_start_unr.push_back(unr);
            eth_cs = 1'b0;
            cyc(6);
            for (int b = 0; b < 3; b++) begin
                eth_mosi = 1'($urandom);
                cyc(6);
                eth_sck = 1'b1;
                cyc(6);
                eth_sck = 1'b0;
            end
            cyc(2);
            rst_n   = 1'b0;
            eth_cs  = 1'b1;
            eth_sck = 1'b0;
            cyc(1);
            check_reset_outputs("mid-frame reset");
            m_full = 1'b0;
            rst_n  = 1'b1;
            cyc(10);
        end

        // Normal frame after reset.
        host_load(8'h77);
        mosi_q.push_back(8'h3C);
        mosi_q.push_back(8'hC5);
        frame(2, 0, 6);

        // byte_count saturation (CW=3 -> 7).
        frame(9, 0, 4);

        // Randomised frames.
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(1, 0) == 1) host_load(8'($urandom));
            frame($urandom_range(3, 0), $urandom_range(5, 0), $urandom_range(9, 4));
            chk("tx_ready between frames", tx_ready, !m_full);
        end

        cyc(50);
        chk("pending rx expectations", exp_rx.size(), 0);
        chk("pending frame_end expectations", exp_cnt.size(), 0);
        chk("pending frame_start expectations", exp_start_unr.size(), 0);
        chk("pending miso expectations", exp_miso.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
